aftab_booth_multiplier: RTL and testbench

//   Sequential radix-2 Booth multiplier for signed two's-complement operands, used by the

---
 rtl/aftab_booth_multiplier.sv | 94 +++++++++
 tb/tb_aftab_booth_multiplier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_booth_multiplier.sv
// rtl/aftab_booth_multiplier.sv - sequential radix-2 Booth multiplier, one step per clock
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   start - request, sampled only while idle
//   M     - signed multiplicand (size bits)
//   Q     - signed multiplier (size bits)
//   done  - one-cycle pulse, product valid on P
//   P     - registered signed product M*Q (2*size bits), held until the next result
module aftab_booth_multiplier #(
    parameter int size = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [size-1:0]       M,
    input  logic [size-1:0]       Q,
    output logic                  done,
    output logic [2*size-1:0]     P
);

    localparam int CW = $clog2(size + 1);
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [size:0]   acc;      // accumulator with one guard bit
    logic [size:0]   mr;       // sign-extended multiplicand
    logic [size-1:0] qr;       // multiplier, shifted right each step
    logic            q_1;      // Booth look-behind bit
    logic [CW-1:0]   cnt;
    logic [size:0]   acc_next;

    // Booth recoding of {qr[0], q_1}: 10 subtract, 01 add, otherwise hold.
    always_comb begin
        acc_next = acc;
        case ({qr[0], q_1})
            2'b10:   acc_next = acc - mr;
            2'b01:   acc_next = acc + mr;
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            mr    <= '0;
            qr    <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            P     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        qr    <= Q;
                        q_1   <= 1'b0;
                        mr    <= {M[size-1], M};
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Arithmetic right shift of {acc_next, qr, q_1} by one.
                    acc <= {acc_next[size], acc_next[size:1]};
                    qr  <= {acc_next[0], qr[size-1:1]};
                    q_1 <= qr[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Guard bit is dropped; the low 2*size bits are the exact product.
                    P     <= {acc[size-1:0], qr};
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_booth_multiplier.sv
// tb/tb_aftab_booth_multiplier.sv - self-checking bench for aftab_booth_multiplier
module tb_aftab_booth_multiplier;

    localparam int SZ = 33;
    localparam int LAT = SZ + 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic [SZ-1:0]   M;
    logic [SZ-1:0]   Q;
    logic            done;
    logic [2*SZ-1:0] P;

    int n_cmp;
    int n_bad;

    aftab_booth_multiplier #(.size(SZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .M     (M),
        .Q     (Q),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed multiplication at full product width.
    function automatic logic [2*SZ-1:0] ref_mul(input logic [SZ-1:0] m, input logic [SZ-1:0] q);
        logic signed [2*SZ-1:0] em;
        logic signed [2*SZ-1:0] eq;
        em = {{SZ{m[SZ-1]}}, m};
        eq = {{SZ{q[SZ-1]}}, q};
        return em * eq;
    endfunction

    function automatic logic [SZ-1:0] rnd33();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[SZ-1:0];
    endfunction

    // Launches one operation from idle, checks latency, product, pulse width, hold.
    // scramble: wiggle M/Q and pulse start while busy.
    task automatic run_op(input logic [SZ-1:0] m, input logic [SZ-1:0] q,
                          input int hold, input bit scramble, input string name);
        logic [2*SZ-1:0] exp;
        int n;
        bit seen;
        exp = ref_mul(m, q);
        @(negedge clk);
        M = m; Q = q; start = 1'b1;
        @(posedge clk);
        n = 0;
        seen = 0;
        #1;
        if (hold <= 1) start = 1'b0;
        while (n < LAT + 6 && !seen) begin
            @(posedge clk);
            n++;
            #1;
            if (scramble && n < 20) begin
                M = rnd33();
                Q = rnd33();
                start = (n % 3 == 0);
            end else if (n >= hold - 1 || n >= 20) begin
                start = 1'b0;
            end
            if (done) seen = 1;
        end
        n_cmp++;
        if (!seen || n != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges (seen=%0d), expected %0d", name, n, seen, LAT);
        end
        n_cmp++;
        if (P !== exp) begin
            n_bad++;
            $display("FAIL %s product: got %h, expected %h", name, P, exp);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done width: done=%b one cycle later, expected 0", name, done);
        end
        n_cmp++;
        if (P !== exp) begin
            n_bad++;
            $display("FAIL %s hold: P=%h, expected %h", name, P, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; M = '0; Q = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || P !== '0) begin
            n_bad++;
            $display("FAIL reset_state: done=%b P=%h, expected 0 and 0", done, P);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        run_op(33'd50, -33'sd3, 2, 0, "m50_qm3");
        n_cmp++;
        if (P !== 66'h3_FFFF_FFFF_FFFF_FF6A) begin
            n_bad++;
            $display("FAIL m50_qm3 literal: got %h, expected 3ffffffffffffff6a", P);
        end
        run_op(33'd0, -33'sd12345, 1, 0, "zero_m");
        run_op(33'd7, 33'd6, 1, 0, "seven_six");
        run_op(33'h1_0000_0000, 33'h1_0000_0000, 1, 0, "min_min");
        n_cmp++;
        if (P !== 66'h1_0000_0000_0000_0000) begin
            n_bad++;
            $display("FAIL min_min literal: got %h, expected 10000000000000000", P);
        end
        run_op(33'h1_0000_0000, {SZ{1'b1}}, 3, 0, "min_m1");
        run_op({SZ{1'b1}}, {SZ{1'b1}}, 1, 0, "m1_m1");
        run_op(33'h0_FFFF_FFFF, 33'h1_0000_0000, 1, 0, "max_min");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_op(rnd33(), rnd33(), int'($urandom_range(1, 4)), 0, "random");
        end
    endtask

    task automatic test_midop_change();
        for (int i = 0; i < 3; i++) begin
            run_op(rnd33(), rnd33(), 1, 1, "midop_change");
        end
    endtask

    task automatic test_reset_midop();
        int pulses;
        @(negedge clk);
        M = 33'd1234; Q = 33'd5678; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || P !== '0) begin
            n_bad++;
            $display("FAIL reset_midop: done=%b P=%h, expected 0 and 0", done, P);
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || P !== '0) begin
            n_bad++;
            $display("FAIL reset_abort: %0d done pulses, P=%h, expected 0 and 0", pulses, P);
        end
        run_op(-33'sd77, 33'd1001, 1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [SZ-1:0] ms [3];
        logic [SZ-1:0] qs [3];
        logic [2*SZ-1:0] held;
        int k;
        int n;
        int unstable;
        for (int i = 0; i < 3; i++) begin
            ms[i] = rnd33();
            qs[i] = rnd33();
        end
        @(negedge clk);
        M = ms[0]; Q = qs[0]; start = 1'b1;
        @(posedge clk);
        k = 0;
        n = 0;
        unstable = 0;
        held = P;
        while (k < 3 && n < 4 * (LAT + 2)) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                n_cmp++;
                if (P !== ref_mul(ms[k], qs[k])) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d]: got %h, expected %h", k, P, ref_mul(ms[k], qs[k]));
                end
                k++;
                held = P;
                if (k < 3) begin
                    M = ms[k]; Q = qs[k];
                end else begin
                    start = 1'b0;
                end
            end else if (P !== held) begin
                unstable++;
            end
        end
        n_cmp++;
        if (k != 3 || n != 3 * (LAT + 1) - 1 || unstable != 0) begin
            n_bad++;
            $display("FAIL back_to_back timing: %0d results in %0d edges, %0d unstable, expected 3 in %0d, 0",
                     k, n, unstable, 3 * (LAT + 1) - 1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_midop_change();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
